// File: rtl/vedic_mult_arbiter.sv
// vedic_mult_arbiter: round-robin sharing of one 8x8 vedic multiplier between NUM_REQ requesters.
// Two-stage pipeline: operand register (S1) -> multiplier -> result register (S2).
module vedic_2x2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] q
);
    logic c;
    assign c = (a[1] & b[0]) & (a[0] & b[1]);
    assign q = {a[1] & b[1] & c, (a[1] & b[1]) ^ c, (a[1] & b[0]) ^ (a[0] & b[1]), a[0] & b[0]};
endmodule

module vedic_4x4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] q
);
    logic [3:0] ll, lh, hl, hh;
    vedic_2x2 u_ll (.a(a[1:0]), .b(b[1:0]), .q(ll));
    vedic_2x2 u_lh (.a(a[1:0]), .b(b[3:2]), .q(lh));
    vedic_2x2 u_hl (.a(a[3:2]), .b(b[1:0]), .q(hl));
    vedic_2x2 u_hh (.a(a[3:2]), .b(b[3:2]), .q(hh));
    assign q = {4'b0, ll} + {2'b0, lh, 2'b0} + {2'b0, hl, 2'b0} + {hh, 4'b0};
endmodule

module vedic_8x8 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] q
);
    logic [7:0] ll, lh, hl, hh;
    vedic_4x4 u_ll (.a(a[3:0]), .b(b[3:0]), .q(ll));
    vedic_4x4 u_lh (.a(a[3:0]), .b(b[7:4]), .q(lh));
    vedic_4x4 u_hl (.a(a[7:4]), .b(b[3:0]), .q(hl));
    vedic_4x4 u_hh (.a(a[7:4]), .b(b[7:4]), .q(hh));
    assign q = {8'b0, ll} + {4'b0, lh, 4'b0} + {4'b0, hl, 4'b0} + {hh, 8'b0};
endmodule

module vedic_mult_arbiter #(
    parameter int RANGE_WIDTH = 16,
    parameter int NUM_REQ     = 2,
    parameter int ID_WIDTH    = 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ*RANGE_WIDTH/2-1:0]  req_m,
    input  logic [NUM_REQ*RANGE_WIDTH/2-1:0]  req_p,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [ID_WIDTH-1:0]               rsp_id,
    output logic [RANGE_WIDTH-1:0]            rsp_result
);
    localparam int OW = RANGE_WIDTH / 2;

    if (RANGE_WIDTH != 16) begin : g_bad_width
        $error("vedic_mult_arbiter: only RANGE_WIDTH=16 is supported");
    end
    if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_num_req
        $error("vedic_mult_arbiter: NUM_REQ must be 2..4");
    end
    if (ID_WIDTH != $clog2(NUM_REQ)) begin : g_bad_id_width
        $error("vedic_mult_arbiter: ID_WIDTH must equal clog2(NUM_REQ)");
    end

    logic                   s1_valid, s2_valid;
    logic [OW-1:0]          s1_m, s1_p;
    logic [ID_WIDTH-1:0]    s1_id, s2_id, rr_ptr, gnt_id, idx, rr_next;
    logic [RANGE_WIDTH-1:0] prod, s2_prod;
    logic                   adv1, adv2, gnt_any, fire;

    vedic_8x8 u_mul (.a(s1_m), .b(s1_p), .q(prod));

    assign adv2       = !s2_valid || rsp_ready;
    assign adv1       = !s1_valid || adv2;
    assign fire       = gnt_any && adv1 && !reset;
    assign rr_next    = (gnt_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_id + ID_WIDTH'(1);
    assign rsp_valid  = s2_valid;
    assign rsp_id     = s2_id;
    assign rsp_result = s2_prod;

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_WIDTH'((int'(rr_ptr) + k) % NUM_REQ);
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (fire) req_ready[gnt_id] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_m     <= '0;
            s1_p     <= '0;
            s1_id    <= '0;
            s2_valid <= 1'b0;
            s2_prod  <= '0;
            s2_id    <= '0;
            rr_ptr   <= '0;
        end else begin
            if (adv2) begin
                s2_valid <= s1_valid;
                s2_prod  <= prod;
                s2_id    <= s1_id;
            end
            if (adv1) s1_valid <= fire;
            if (fire) begin
                s1_m   <= req_m[int'(gnt_id)*OW +: OW];
                s1_p   <= req_p[int'(gnt_id)*OW +: OW];
                s1_id  <= gnt_id;
                rr_ptr <= rr_next;
            end
        end
    end
endmodule

// File: tb/tb_vedic_mult_arbiter.sv
// tb_vedic_mult_arbiter: directed vectors, corner sequences and a random scoreboard run on a 4-requester arbiter.
module tb_vedic_mult_arbiter;
    localparam int N = 4;

    typedef struct {
        int         id;
        logic [7:0] m;
        logic [7:0] p;
        logic [15:0] exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  req_valid = '0;
    logic [N-1:0]  req_ready;
    logic [7:0]    m[N];
    logic [7:0]    p[N];
    logic [N*8-1:0] req_m, req_p;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [1:0]    rsp_id;
    logic [15:0]   rsp_result;

    int            n_cmp = 0;
    int            n_fail = 0;
    int            issued = 0;
    int            wait_cnt[N];
    logic [15:0]   exp_q[N][$];
    logic [N-1:0]  fired;
    vec_t          vecs[10];

    assign req_m = {m[3], m[2], m[1], m[0]};
    assign req_p = {p[3], p[2], p[1], p[0]};

    vedic_mult_arbiter #(.RANGE_WIDTH(16), .NUM_REQ(N), .ID_WIDTH(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_m(req_m), .req_p(req_p),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_result(rsp_result)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic single_op(input string tag, input int id, input logic [7:0] a, input logic [7:0] b,
                             input logic [15:0] exp);
        m[id] = a;
        p[id] = b;
        req_valid = N'(1) << id;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_ready"}, 32'(req_ready), 32'(1) << id);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk({tag, "_valid_lat1"}, 32'(rsp_valid), 0);
        tick();
        @(negedge clk);
        chk({tag, "_valid_lat2"}, 32'(rsp_valid), 1);
        chk({tag, "_result"}, 32'(rsp_result), 32'(exp));
        chk({tag, "_id"}, 32'(rsp_id), id);
        tick();
        @(negedge clk);
        chk({tag, "_valid_after"}, 32'(rsp_valid), 0);
        tick();
    endtask

    // Flush expectations the moment reset rises: in-flight products are discarded.
    initial forever begin
        @(posedge reset);
        for (int i = 0; i < N; i++) exp_q[i].delete();
    end

    initial forever begin
        @(negedge clk);
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                exp_q[i].delete();
                wait_cnt[i] = 0;
            end
        end else begin
            n_cmp++;
            if ($countones(req_ready) > 1) begin
                n_fail++;
                $display("FAIL ready_onehot: got %b, expected at most one bit", req_ready);
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q[rsp_id].size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL rsp_unexpected: id %0d got %0h, expected no response", rsp_id, rsp_result);
                end else begin
                    chk($sformatf("scoreboard_id%0d", rsp_id), 32'(rsp_result), 32'(exp_q[rsp_id].pop_front()));
                end
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    exp_q[i].push_back(16'(m[i]) * 16'(p[i]));
                    n_cmp++;
                    if (wait_cnt[i] > N - 1) begin
                        n_fail++;
                        $display("FAIL fairness req%0d: waited %0d grants, expected at most %0d", i, wait_cnt[i], N - 1);
                    end
                    wait_cnt[i] = 0;
                end else if (req_valid[i]) begin
                    wait_cnt[i] += (|(req_valid & req_ready)) ? 1 : 0;
                end else begin
                    wait_cnt[i] = 0;
                end
            end
        end
    end

    initial begin
        vecs[0] = '{0, 8'h12, 8'h34, 16'h03A8};
        vecs[1] = '{1, 8'h00, 8'hAB, 16'h0000};
        vecs[2] = '{2, 8'h01, 8'hFF, 16'h00FF};
        vecs[3] = '{3, 8'hFF, 8'h01, 16'h00FF};
        vecs[4] = '{0, 8'hFF, 8'hFF, 16'hFE01};
        vecs[5] = '{1, 8'h0F, 8'h0F, 16'h00E1};
        vecs[6] = '{2, 8'hAA, 8'h55, 16'h3872};
        vecs[7] = '{3, 8'h10, 8'h10, 16'h0100};
        vecs[8] = '{0, 8'hFE, 8'hFE, 16'hFC04};
        vecs[9] = '{1, 8'h7F, 8'h81, 16'h3FFF};
        for (int i = 0; i < N; i++) begin
            m[i] = '0;
            p[i] = '0;
        end

        req_valid = 4'b0001;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rsp_valid", 32'(rsp_valid), 0);
        chk("reset_rsp_result", 32'(rsp_result), 0);
        chk("reset_rsp_id", 32'(rsp_id), 0);
        chk("reset_req_ready", 32'(req_ready), 0);
        req_valid = '0;
        tick();
        reset = 1'b0;

        for (int i = 0; i < 10; i++)
            single_op($sformatf("vec%0d", i), vecs[i].id, vecs[i].m, vecs[i].p, vecs[i].exp);

        // Two requesters saturating: grants alternate and results stream without bubbles.
        do_reset();
        m[0] = 8'hFF; p[0] = 8'hFF;
        m[1] = 8'h80; p[1] = 8'h02;
        req_valid = 4'b0011;
        rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("alt_ready%0d", k), 32'(req_ready), (k % 2) ? 2 : 1);
            if (k >= 2) begin
                chk($sformatf("alt_valid%0d", k), 32'(rsp_valid), 1);
                chk($sformatf("alt_id%0d", k), 32'(rsp_id), k % 2);
                chk($sformatf("alt_result%0d", k), 32'(rsp_result), (k % 2) ? 32'h0100 : 32'hFE01);
            end
            tick();
        end
        req_valid = '0;
        repeat (3) tick();

        // Backpressure: three req0 ops with the consumer stalled for four cycles.
        rsp_ready = 1'b0;
        m[0] = 8'd2; p[0] = 8'd3;
        req_valid = 4'b0001;
        @(negedge clk);
        chk("bp_ready_c0", 32'(req_ready), 1);
        tick();
        m[0] = 8'd4; p[0] = 8'd5;
        @(negedge clk);
        chk("bp_ready_c1", 32'(req_ready), 1);
        tick();
        m[0] = 8'd6; p[0] = 8'd7;
        for (int c = 2; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("bp_ready_c%0d", c), 32'(req_ready), 0);
            chk($sformatf("bp_valid_c%0d", c), 32'(rsp_valid), 1);
            chk($sformatf("bp_hold_c%0d", c), 32'(rsp_result), 32'h0006);
            tick();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_c4", 32'(req_ready), 1);
        chk("bp_out0", 32'(rsp_result), 32'h0006);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("bp_out1_valid", 32'(rsp_valid), 1);
        chk("bp_out1", 32'(rsp_result), 32'h0014);
        tick();
        @(negedge clk);
        chk("bp_out2_valid", 32'(rsp_valid), 1);
        chk("bp_out2", 32'(rsp_result), 32'h002A);
        tick();
        @(negedge clk);
        chk("bp_drained", 32'(rsp_valid), 0);
        tick();

        // Reset with both pipeline stages occupied.
        rsp_ready = 1'b0;
        m[0] = 8'h55; p[0] = 8'h03;
        m[1] = 8'h66; p[1] = 8'h02;
        req_valid = 4'b0011;
        repeat (2) tick();
        @(negedge clk);
        chk("rst_pre_valid", 32'(rsp_valid), 1);
        chk("rst_pre_ready", 32'(req_ready), 0);
        #1 reset = 1'b1;
        #1;
        chk("rst_async_valid", 32'(rsp_valid), 0);
        chk("rst_async_result", 32'(rsp_result), 0);
        m[0] = 8'h11; p[0] = 8'h11;
        m[1] = 8'h22; p[1] = 8'h02;
        rsp_ready = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_rr_ptr_req0_wins", 32'(req_ready), 1);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("rst_no_stale", 32'(rsp_valid), 0);
        tick();
        @(negedge clk);
        chk("rst_new_valid", 32'(rsp_valid), 1);
        chk("rst_new_id", 32'(rsp_id), 0);
        chk("rst_new_result", 32'(rsp_result), 32'h0121);
        tick();
        @(negedge clk);
        chk("rst_new_done", 32'(rsp_valid), 0);
        tick();

        // Random regression: operands change only after their own handshake.
        for (int cyc = 0; cyc < 40000 && issued < 10000; cyc++) begin
            @(negedge clk);
            fired = req_valid & req_ready;
            tick();
            for (int i = 0; i < N; i++) begin
                if (fired[i]) begin
                    issued++;
                    req_valid[i] = ($urandom_range(0, 3) != 0);
                    m[i] = 8'($urandom);
                    p[i] = 8'($urandom);
                end else if (!req_valid[i] && ($urandom_range(0, 1) == 1)) begin
                    m[i] = 8'($urandom);
                    p[i] = 8'($urandom);
                    req_valid[i] = 1'b1;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        chk("random_ops_issued", 32'(issued >= 10000), 1);
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (10) tick();
        @(negedge clk);
        for (int i = 0; i < N; i++)
            chk($sformatf("drain_empty_req%0d", i), exp_q[i].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
